// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, byte/column/state types, GF(2^8)
// helpers and the InvMixColumns coefficients.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [7:0]             aes_byte_t;
    typedef logic [31:0]            aes_col_t;
    typedef logic [AES_BLOCK_W-1:0] aes_state_t;

    // First row of the InvMixColumns matrix; later rows are right rotations of it
    localparam aes_byte_t INV_MIX_C0 = 8'h0e;
    localparam aes_byte_t INV_MIX_C1 = 8'h0b;
    localparam aes_byte_t INV_MIX_C2 = 8'h0d;
    localparam aes_byte_t INV_MIX_C3 = 8'h09;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply as an xtime chain; with a constant b this reduces to a few XORs
    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t acc;
        aes_byte_t pow;
        acc = 8'h00;
        pow = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ pow;
            end
            pow = xtime(pow);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_round_if.sv
// Transaction bus of the AES inverse-round datapath: controller (master)
// drives state/key/controls, the datapath (slave) returns the result.
interface aes_inv_round_if;
    import aes_pkg::*;

    logic       in_valid;
    aes_state_t in_state;
    aes_state_t in_key;
    logic       shift_en;
    logic       mix_en;
    logic       out_valid;
    aes_state_t out_state;

    modport master (
        output in_valid, in_state, in_key, shift_en, mix_en,
        input  out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_key, shift_en, mix_en,
        output out_valid, out_state
    );

endinterface

// File: rtl/aes_inv_mix_col.sv
// InvMixColumns on one 32-bit column (row 0 in the top byte); purely combinational.
module aes_inv_mix_col
    import aes_pkg::*;
(
    input  aes_col_t col_in,
    output aes_col_t col_out
);

    aes_byte_t a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gf_mul(a0, INV_MIX_C0) ^ gf_mul(a1, INV_MIX_C1) ^ gf_mul(a2, INV_MIX_C2) ^ gf_mul(a3, INV_MIX_C3);
    assign col_out[23:16] = gf_mul(a0, INV_MIX_C3) ^ gf_mul(a1, INV_MIX_C0) ^ gf_mul(a2, INV_MIX_C1) ^ gf_mul(a3, INV_MIX_C2);
    assign col_out[15:8]  = gf_mul(a0, INV_MIX_C2) ^ gf_mul(a1, INV_MIX_C3) ^ gf_mul(a2, INV_MIX_C0) ^ gf_mul(a3, INV_MIX_C1);
    assign col_out[7:0]   = gf_mul(a0, INV_MIX_C1) ^ gf_mul(a1, INV_MIX_C2) ^ gf_mul(a2, INV_MIX_C3) ^ gf_mul(a3, INV_MIX_C0);

endmodule

// File: rtl/aes_inv_round.sv
// AES inverse round: InvShiftRows -> AddRoundKey -> optional InvMixColumns,
// one state per cycle, valid-qualified, no backpressure.
// Define AES_INV_ROUND_PIPE_EN to register the AddRoundKey result
// (latency 2 instead of 1); results are identical in both builds.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    aes_inv_round_if.slave  bus
);

    aes_state_t shifted;
    aes_state_t added;
    aes_state_t mix_src;
    aes_state_t mixed;
    aes_state_t result;
    logic       mix_sel;
    logic       stage_valid;

    aes_state_t out_state_q, out_state_d;
    logic       out_valid_q, out_valid_d;

    // InvShiftRows: row r rotates right by r, so s[r,c] lands in column (c+r) mod 4
    always_comb begin
        shifted = bus.in_state;
        if (bus.shift_en) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    shifted[AES_BLOCK_W-1-8*(r+4*((c+r)%4)) -: 8] = bus.in_state[AES_BLOCK_W-1-8*(r+4*c) -: 8];
                end
            end
        end
    end

    assign added = shifted ^ bus.in_key;

`ifdef AES_INV_ROUND_PIPE_EN
    aes_state_t u_q, u_d;
    logic       mix_q, mix_d;
    logic       mid_valid_q, mid_valid_d;

    // Middle stage captures the keyed state and its mix control only for valid inputs
    always_comb begin
        mid_valid_d = bus.in_valid;
        u_d         = u_q;
        mix_d       = mix_q;
        if (bus.in_valid) begin
            u_d   = added;
            mix_d = bus.mix_en;
        end
    end

    // Middle stage registers; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            u_q         <= '0;
            mix_q       <= 1'b0;
            mid_valid_q <= 1'b0;
        end else begin
            u_q         <= u_d;
            mix_q       <= mix_d;
            mid_valid_q <= mid_valid_d;
        end
    end

    assign mix_src     = u_q;
    assign mix_sel     = mix_q;
    assign stage_valid = mid_valid_q;
`else
    assign mix_src     = added;
    assign mix_sel     = bus.mix_en;
    assign stage_valid = bus.in_valid;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_col
        aes_inv_mix_col u_mix_col (
            .col_in  (mix_src[AES_BLOCK_W-1-32*g -: 32]),
            .col_out (mixed[AES_BLOCK_W-1-32*g -: 32])
        );
    end

    assign result = mix_sel ? mixed : mix_src;

    // Output stage: load the result only for a valid transaction, otherwise hold
    always_comb begin
        out_valid_d = stage_valid;
        out_state_d = out_state_q;
        if (stage_valid) begin
            out_state_d = result;
        end
    end

    // Output registers with synchronous reset taking priority over new data
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_aes_inv_round.sv
// Self-checking bench for aes_inv_round: reference model of the AES inverse
// round built on a 4x4 byte matrix, checked against the DUT every cycle,
// plus directed vectors with hand-computed results.
module tb_aes_inv_round;

`ifdef AES_INV_ROUND_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    aes_inv_round_if bus_if ();

    aes_inv_round dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic         m_valid;
    logic [127:0] m_state;
    logic         pv [LAT];
    logic [127:0] ps [LAT];

    // GF(2^8) multiply by shift-and-add then polynomial long division by 0x11b
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        end
        return prod[7:0];
    endfunction

    // Whole inverse round on a byte matrix m[r][c] = byte r+4c
    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                                input logic sh, input logic mx);
        logic [7:0] m [4][4];
        logic [7:0] t [4][4];
        logic [7:0] coef [4][4];
        logic [127:0] res;
        coef = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                 '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                 '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                 '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = s[127-8*(r+4*c) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][sh ? (c + r) % 4 : c] = m[r][c];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = t[r][c] ^ k[127-8*(r+4*c) -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc;
                if (mx) begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc = acc ^ ref_mul(coef[r][j], t[j][c]);
                end else begin
                    acc = t[r][c];
                end
                res[127-8*(r+4*c) -: 8] = acc;
            end
        end
        return res;
    endfunction

    // Reference pipeline: each accepted input emerges LAT edges later; output held otherwise
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] = 1'b0;
                ps[i] = '0;
            end
            m_valid = 1'b0;
            m_state = '0;
        end else begin
            for (int i = LAT - 1; i >= 1; i--) begin
                pv[i] = pv[i-1];
                ps[i] = ps[i-1];
            end
            pv[0] = bus_if.in_valid;
            ps[0] = ref_round(bus_if.in_state, bus_if.in_key, bus_if.shift_en, bus_if.mix_en);
            m_valid = pv[LAT-1];
            if (pv[LAT-1]) m_state = ps[LAT-1];
        end
    end

    // Compare DUT against the reference on every falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            checks = checks + 1;
            if (bus_if.out_valid !== m_valid) begin
                errors = errors + 1;
                $display("[TB] FAIL out_valid t=%0t actual=%b expected=%b", $time, bus_if.out_valid, m_valid);
            end
            checks = checks + 1;
            if (bus_if.out_state !== m_state) begin
                errors = errors + 1;
                $display("[TB] FAIL out_state t=%0t actual=%h expected=%h", $time, bus_if.out_state, m_state);
            end
        end
    end

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [127:0] s, input logic [127:0] k,
                                  input logic sh, input logic mx);
        bus_if.in_valid = v;
        bus_if.in_state = s;
        bus_if.in_key   = k;
        bus_if.shift_en = sh;
        bus_if.mix_en   = mx;
        @(posedge clk);
        #1;
    endtask

    // One transaction followed by idle cycles; checks latency and the literal result
    task automatic directed(input string name, input logic [127:0] s, input logic [127:0] k,
                            input logic sh, input logic mx, input logic [127:0] expected);
        int n;
        apply_stimulus(1'b1, s, k, sh, mx);
        bus_if.in_valid = 1'b0;
        n = 0;
        while (bus_if.out_valid !== 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus_if.out_valid !== 1'b1) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL %s_timeout actual=no_out_valid expected=out_valid", name);
        end else begin
            check_output({name, "_latency"}, 128'(n + 1), 128'(LAT));
            check_output(name, bus_if.out_state, expected);
        end
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vcount;
        reset = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_state = '0;
        bus_if.in_key   = '0;
        bus_if.shift_en = 1'b0;
        bus_if.mix_en   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("reset_out_valid", 128'(bus_if.out_valid), 128'(0));
        check_output("reset_out_state", bus_if.out_state, '0);
        cmp_en = 1'b1;
        reset  = 1'b0;

        $display("[TB] pinning reference model against hand-computed vectors");
        check_output("model_shift", ref_round(128'h00112233445566778899aabbccddeeff, '0, 1'b1, 1'b0),
                     128'h00ddaa774411eebb885522ffcc996633);
        check_output("model_mix", ref_round(128'h9fdc589d01010101c6c6c6c6d4d4d4d5, '0, 1'b0, 1'b1),
                     128'hf20a225c01010101c6c6c6c6ddd9dfda);
        check_output("model_key", ref_round(128'hffffffff00000000ffffffff00000000,
                     128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b0, 1'b0),
                     128'hf0f0f0f00f0f0f0ff0f0f0f00f0f0f0f);

        $display("[TB] directed vectors");
        directed("dut_shift", 128'h00112233445566778899aabbccddeeff, '0, 1'b1, 1'b0,
                 128'h00ddaa774411eebb885522ffcc996633);
        directed("dut_mix", 128'h9fdc589d01010101c6c6c6c6d4d4d4d5, '0, 1'b0, 1'b1,
                 128'hf20a225c01010101c6c6c6c6ddd9dfda);
        directed("dut_key", 128'hffffffff00000000ffffffff00000000,
                 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b0, 1'b0,
                 128'hf0f0f0f00f0f0f0ff0f0f0f00f0f0f0f);

        $display("[TB] 100 back-to-back random rounds");
        vcount = 0;
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(1'b1, rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i >= LAT - 1 && bus_if.out_valid === 1'b1) vcount++;
        end
        check_output("back_to_back_valid_count", 128'(vcount), 128'(100 - (LAT - 1)));
        for (int i = 0; i < LAT + 1; i++) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);

        $display("[TB] reset mid-stream");
        apply_stimulus(1'b1, rnd128(), rnd128(), 1'b1, 1'b1);
        reset = 1'b1;
        apply_stimulus(1'b1, rnd128(), rnd128(), 1'b1, 1'b1);
        check_output("midreset_out_valid", 128'(bus_if.out_valid), 128'(0));
        check_output("midreset_out_state", bus_if.out_state, '0);
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
            if (bus_if.out_valid !== 1'b0) vcount++;
        end
        check_output("no_stale_after_reset", 128'(vcount), 128'(0));

        $display("[TB] bubbles");
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'(i % 2 == 0), rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < LAT + 2; i++) apply_stimulus(1'b0, rnd128(), rnd128(), 1'b1, 1'b1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_round.md
# aes_inv_round

Registered AES inverse-round datapath for the decryption core. It applies InvShiftRows, then AddRoundKey, then optionally InvMixColumns to one 128-bit state per cycle. The cipher controller drives it once per round and handles InvSubBytes and key scheduling itself. It is fully pipelined, with a valid qualifier and no backpressure.

## Interface
Parameters:
- none

Ports (reset reset, synchronous, active-high; clock clk):
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers
- in_valid  input  1  qualifies in_state/in_key/controls this cycle
- in_state  input  128  state; byte k = bits[127-8k -: 8]; s[r,c] = byte r+4c
- in_key  input  128  round key, same byte order
- shift_en  input  1  1 = apply InvShiftRows; 0 = pass state unshifted
- mix_en  input  1  1 = apply InvMixColumns after AddRoundKey; 0 = skip (final round)
- out_valid  output  1  out_state holds a result
- out_state  output  128  result, same byte order

## Operation
- Step 1, InvShiftRows (if shift_en):
  - t[r,(c+r) mod 4] = s[r,c]
  - row r rotates right by r; row 0 unchanged.
- Step 2, AddRoundKey: u = t XOR in_key, bitwise over all 128 bits.
- Step 3, InvMixColumns (if mix_en), applied to each column independently:
  - Column matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
  - Multiplication is in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1 (0x11b).
  - Addition is XOR.
  - Implemented with xtime chains; no lookup ROM.
- shift_en=0 and mix_en=0 gives a plain key XOR, used for the initial AddRoundKey.
- Controls are sampled with their data; each transaction is independent.
- in_valid=0: the pipeline advances with valid=0.
  - out_state holds its last value.
  - Data registers load only when the incoming valid is 1.

## Timing
- Reset: out_valid=0, out_state=128'h0; any in-flight transaction is discarded.
- Reset has priority over in_valid in the same cycle.
- Latency 1 cycle (2 with AES_INV_ROUND_PIPE_EN).
  - Input accepted at edge N appears at edge N+latency with out_valid=1.
- Throughput: one transaction per cycle; back-to-back inputs give back-to-back outputs.
- No stall or ready signal; the consumer must sample when out_valid=1.
- out_valid is high for exactly one cycle per accepted input.

## Configuration
- AES_INV_ROUND_PIPE_EN defined:
  - Adds an internal register stage after AddRoundKey, carrying u, mix_en and valid.
  - Latency becomes 2.
- Undefined: the whole datapath is combinational into a single output register; latency 1.
- Functional results are identical in both builds; only latency differs.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCK_W=128
  - byte/column/state typedefs
  - the xtime and gf_mul function
  - the InvMixColumns coefficient constants
- One sub-module, aes_inv_mix_col: 32-bit column in, 32-bit column out, purely combinational.
  - Instantiated 4 times.
- InvShiftRows and AddRoundKey are wiring and XOR in the top module.

## Test plan
- InvShiftRows only: in_state=00112233445566778899aabbccddeeff, key=0, shift_en=1, mix_en=0 -> out_state=00ddaa774411eebb885522ffcc996633.
- InvMixColumns columns: shift_en=0, key=0, mix_en=1.
  - in_state=9fdc589d01010101c6c6c6c6d4d4d4d5 -> out_state columns f20a225c, 01010101, c6c6c6c6.
  - Last column checked against a software model.
- Key XOR only: state=ffffffff00000000ffffffff00000000, key=0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, both enables 0 -> f0f0f0f00f0f0f0ff0f0f0f00f0f0f0f.
- Full round, 100 random vectors (state, key, enables) vs. reference model.
  - Inputs back-to-back -> outputs back-to-back at the configured latency.
- Reset mid-stream: assert reset while in_valid=1.
  - Next cycle: out_valid=0, out_state=0.
  - No stale result emerges after reset deasserts.
- Bubbles: alternate in_valid 1/0.
  - out_valid pattern equals the input pattern delayed by the latency.
  - out_state is held during bubbles.
